pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and generates their stall, flush and hold controls. It covers three cases: load-use hazards, EX-stage control redirects (taken branch, jump, jr) and data-memory wait states. A small FSM tracks the active condition, and a watchdog flags a memory that never answers.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use, redirect, memory wait.
// Optional macro HAZCTRL_PERF_EN builds the stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_memtoreg,
  input  logic        ex_regwriteen,
  input  logic [4:0]  ex_wreg,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  state_t          st_q;
  state_t          st_d;
  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;
  logic            to_q;
  logic            rs_hit;
  logic            rt_hit;
  logic            ldhaz;
  logic            memstall;

  assign rs_hit   = id_use_rs && (id_rs == ex_wreg);
  assign rt_hit   = id_use_rt && (id_rt == ex_wreg);
  assign ldhaz    = ex_memtoreg && ex_regwriteen &&
                    (ex_wreg != 5'd0) && (rs_hit || rt_hit);
  assign memstall = mem_req && !mem_ready;

  // State register, watchdog counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= RUN;
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (cnt_d == TO_MAX) begin
        to_q <= 1'b1;
      end
    end
  end

  // Prioritised controls; memstall wins and defers any redirect in EX
  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    idex_hold  = 1'b0;
    exmem_hold = 1'b0;
    st_d       = RUN;
    if (!reset) begin
      priority case (1'b1)
        memstall: begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_hold  = 1'b1;
          exmem_hold = 1'b1;
          st_d       = MEMWAIT;
        end
        ex_redirect: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        ldhaz: begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          st_d       = LDUSE;
        end
        default: begin
        end
      endcase
    end
  end

  // Watchdog counts stalled MEMWAIT cycles, saturating at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (st_d != MEMWAIT) begin
      cnt_d = '0;
    end else if (st_q == MEMWAIT && memstall && cnt_q != TO_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign state       = st_q;
  assign mem_timeout = to_q;

`ifdef HAZCTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(pc_stall);
      flush_q <= flush_q + 32'(idex_flush);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Instance uses TIMEOUT=4 so the watchdog scenario stays short.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        ex_memtoreg;
  logic        ex_regwriteen;
  logic [4:0]  ex_wreg;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_flush;
  logic        idex_hold;
  logic        exmem_hold;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
  logic [5:0]  ctl;

  int vectors = 0;
  int errs    = 0;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LDU  = 6'b110100;
  localparam logic [5:0] C_MEM  = 6'b110011;
  localparam logic [5:0] C_RED  = 6'b001100;

  assign ctl = {pc_stall, ifid_stall, ifid_flush,
                idex_flush, idex_hold, exmem_hold};

  pipe_hazard_ctrl #(.TO_W(8), .TIMEOUT(4)) dut (
    .clk(clk),
    .reset(reset),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .ex_memtoreg(ex_memtoreg),
    .ex_regwriteen(ex_regwriteen),
    .ex_wreg(ex_wreg),
    .ex_redirect(ex_redirect),
    .mem_req(mem_req),
    .mem_ready(mem_ready),
    .pc_stall(pc_stall),
    .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .idex_hold(idex_hold),
    .exmem_hold(exmem_hold),
    .state(state),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_rs = 5'd0;
    id_rt = 5'd0;
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    ex_memtoreg = 1'b0;
    ex_regwriteen = 1'b0;
    ex_wreg = 5'd0;
    ex_redirect = 1'b0;
    mem_req = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lw8();
    ex_memtoreg = 1'b1;
    ex_regwriteen = 1'b1;
    ex_wreg = 5'd8;
    id_rs = 5'd8;
    id_rt = 5'd9;
    id_use_rs = 1'b1;
    id_use_rt = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    set_lw8();
    mem_req = 1'b1;
    ex_redirect = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_NONE) begin
      errs++;
      $display("FAIL reset_ctl got %b want %b", ctl, C_NONE);
    end
    vectors++;
    if (state !== 2'd0 || mem_timeout !== 1'b0) begin
      errs++;
      $display("FAIL reset_state got %0d/%b want 0/0", state, mem_timeout);
    end
    vectors++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      errs++;
      $display("FAIL reset_perf got %0d/%0d want 0/0",
               stall_cycles, flush_events);
    end
    next_cyc();
    idle();
    reset = 1'b0;
    next_cyc();
  endtask

  task automatic test_load_use();
    set_lw8();
    @(negedge clk);
    vectors++;
    if (ctl !== C_LDU || state !== 2'd0) begin
      errs++;
      $display("FAIL lduse_c0 got %b/%0d want %b/0", ctl, state, C_LDU);
    end
    next_cyc();
    ex_memtoreg = 1'b0;
    ex_regwriteen = 1'b0;
    ex_wreg = 5'd0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_NONE || state !== 2'd1) begin
      errs++;
      $display("FAIL lduse_c1 got %b/%0d want %b/1", ctl, state, C_NONE);
    end
    next_cyc();
    idle();
    @(negedge clk);
    vectors++;
    if (ctl !== C_NONE || state !== 2'd0) begin
      errs++;
      $display("FAIL lduse_c2 got %b/%0d want %b/0", ctl, state, C_NONE);
    end
    set_lw8();
    id_use_rs = 1'b0;
    id_rt = 5'd3;
    #1;
    vectors++;
    if (ctl !== C_NONE) begin
      errs++;
      $display("FAIL lduse_rs_unused got %b want %b", ctl, C_NONE);
    end
    id_rt = 5'd8;
    #1;
    vectors++;
    if (ctl !== C_LDU) begin
      errs++;
      $display("FAIL lduse_rt got %b want %b", ctl, C_LDU);
    end
    ex_regwriteen = 1'b0;
    #1;
    vectors++;
    if (ctl !== C_NONE) begin
      errs++;
      $display("FAIL lduse_nowrite got %b want %b", ctl, C_NONE);
    end
    next_cyc();
    idle();
    next_cyc();
  endtask

  task automatic test_zero_reg();
    ex_memtoreg = 1'b1;
    ex_regwriteen = 1'b1;
    ex_wreg = 5'd0;
    id_use_rs = 1'b1;
    id_use_rt = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_NONE) begin
      errs++;
      $display("FAIL zero_reg got %b want %b", ctl, C_NONE);
    end
    next_cyc();
    @(negedge clk);
    vectors++;
    if (state !== 2'd0) begin
      errs++;
      $display("FAIL zero_reg_state got %0d want 0", state);
    end
    next_cyc();
    idle();
  endtask

  task automatic test_redirect();
    logic [31:0] base;
    set_lw8();
    ex_redirect = 1'b1;
    @(negedge clk);
    base = flush_events;
    vectors++;
    if (ctl !== C_RED) begin
      errs++;
      $display("FAIL redirect got %b want %b", ctl, C_RED);
    end
    next_cyc();
    idle();
    @(negedge clk);
    vectors++;
    if (state !== 2'd0 || ctl !== C_NONE) begin
      errs++;
      $display("FAIL redirect_after got %b/%0d want %b/0",
               ctl, state, C_NONE);
    end
`ifdef HAZCTRL_PERF_EN
    vectors++;
    if (flush_events !== base + 32'd1) begin
      errs++;
      $display("FAIL redirect_perf got %0d want %0d",
               flush_events, base + 32'd1);
    end
`endif
    next_cyc();
  endtask

  task automatic test_mem_wait();
    logic [31:0] base;
    logic [31:0] exp_sc;
    logic [1:0]  exp_st[4];
    exp_st[0] = 2'd0;
    exp_st[1] = 2'd2;
    exp_st[2] = 2'd2;
    exp_st[3] = 2'd2;
    base = 32'd0;
    for (int i = 0; i < 4; i++) begin
      mem_req = 1'b1;
      mem_ready = (i == 3);
      @(negedge clk);
      if (i == 0) base = stall_cycles;
      vectors++;
      if (ctl !== ((i == 3) ? C_NONE : C_MEM) || state !== exp_st[i]) begin
        errs++;
        $display("FAIL memwait_c%0d got %b/%0d want %b/%0d", i, ctl, state,
                 (i == 3) ? C_NONE : C_MEM, exp_st[i]);
      end
      next_cyc();
    end
    idle();
    @(negedge clk);
`ifdef HAZCTRL_PERF_EN
    exp_sc = base + 32'd3;
`else
    exp_sc = 32'd0;
`endif
    vectors++;
    if (state !== 2'd0 || stall_cycles !== exp_sc) begin
      errs++;
      $display("FAIL memwait_end got %0d/%0d want 0/%0d",
               state, stall_cycles, exp_sc);
    end
    next_cyc();
  endtask

  task automatic test_deferred_redirect();
    for (int i = 0; i < 3; i++) begin
      ex_redirect = 1'b1;
      mem_req = 1'b1;
      mem_ready = (i == 2);
      @(negedge clk);
      vectors++;
      if (ctl !== ((i == 2) ? C_RED : C_MEM)) begin
        errs++;
        $display("FAIL defer_c%0d got %b want %b", i, ctl,
                 (i == 2) ? C_RED : C_MEM);
      end
      next_cyc();
    end
    idle();
    @(negedge clk);
    vectors++;
    if (state !== 2'd0) begin
      errs++;
      $display("FAIL defer_state got %0d want 0", state);
    end
    next_cyc();
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 6; i++) begin
      mem_req = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (mem_timeout !== (i == 5)) begin
        errs++;
        $display("FAIL wdog_c%0d got %b want %b", i, mem_timeout, i == 5);
      end
      next_cyc();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_NONE || mem_timeout !== 1'b1) begin
      errs++;
      $display("FAIL wdog_release got %b/%b want %b/1",
               ctl, mem_timeout, C_NONE);
    end
    next_cyc();
    idle();
    @(negedge clk);
    vectors++;
    if (state !== 2'd0 || mem_timeout !== 1'b1) begin
      errs++;
      $display("FAIL wdog_sticky got %0d/%b want 0/1", state, mem_timeout);
    end
    next_cyc();
    mem_req = 1'b1;
    next_cyc();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (state !== 2'd0 || mem_timeout !== 1'b0 || ctl !== C_NONE) begin
      errs++;
      $display("FAIL wdog_reset got %0d/%b/%b want 0/0/%b",
               state, mem_timeout, ctl, C_NONE);
    end
    next_cyc();
    idle();
    reset = 1'b0;
    next_cyc();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_redirect();
    test_mem_wait();
    test_deferred_redirect();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
